// File: rtl/instr_reg_pkg.sv
// Shared types and constants for the instruction register controller.
package instr_reg_pkg;

    localparam int DEPTH = 32;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef logic signed [31:0] operand2_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7
    } opcode_t;

    typedef logic [PTR_W-1:0] pointer2_t;

    typedef struct packed {
        opcode_t   opc;
        operand2_t opa;
        operand2_t opb;
    } instruction_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } ctrl_state_t;

    // Advance a queue pointer; the pointer width makes 31 -> 0 wrap implicit.
    function automatic pointer2_t ptr_next(input pointer2_t p);
        return p + pointer2_t'(1);
    endfunction

endpackage

// File: rtl/instr_reg_ctrl_rr_arb2.sv
// Two-way round-robin arbiter. The last-grant memory only moves on an
// accepted transfer, so a stalled winner keeps its grant.
module rr_arb2
    import instr_reg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_r;   // 1 = requester 1 was granted last

    // Grant selection: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-grant register; reset to requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/instr_reg_ctrl.sv
// Controller for a 32-entry instruction register used as a circular queue:
// two arbitrated write requesters, one read sequencer with a held response.
module instr_reg_ctrl
    import instr_reg_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  operand2_t            req0_opa,
    input  operand2_t            req0_opb,
    input  opcode_t              req0_opc,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  operand2_t            req1_opa,
    input  operand2_t            req1_opb,
    input  opcode_t              req1_opc,
    output logic                 load_en,
    output operand2_t            operand_a,
    output operand2_t            operand_b,
    output opcode_t              opcode,
    output pointer2_t            write_pointer,
    output pointer2_t            read_pointer,
    input  instruction_t         instruction_word,
    input  logic                 valid,
    input  logic                 rd_req,
    output logic                 rd_ack,
    output logic                 rsp_valid,
    output instruction_t         rsp_word,
    output logic                 rsp_err,
    input  logic                 rsp_ready,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 empty
);

    logic [CNT_W-1:0] count_r;
    pointer2_t        wptr_r;
    pointer2_t        rptr_r;
    ctrl_state_t      state_r;
    ctrl_state_t      state_nxt_s;
    logic             rd_ack_s;
    logic             rd_done_s;
    logic [1:0]       grant_s;
    logic             wr_acc_s;
    logic             load_en_r;
    operand2_t        opa_r;
    operand2_t        opb_r;
    opcode_t          opc_r;
    instruction_t     rsp_word_r;
    logic             rsp_err_r;
    logic             rsp_valid_r;

    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == CNT_W'(0));

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1_valid, req0_valid}),
        .accept  (wr_acc_s),
        .grant   (grant_s)
    );

    // Readies are held low during reset so nothing is accepted into a clearing queue.
    assign req0_ready = reset_n & ~full & grant_s[0];
    assign req1_ready = reset_n & ~full & grant_s[1];
    assign wr_acc_s   = (req0_valid & req0_ready) | (req1_valid & req1_ready);

    assign rd_ack        = rd_ack_s & reset_n;
    assign load_en       = load_en_r;
    assign operand_a     = opa_r;
    assign operand_b     = opb_r;
    assign opcode        = opc_r;
    assign write_pointer = wptr_r;
    assign read_pointer  = rptr_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_word      = rsp_word_r;
    assign rsp_err       = rsp_err_r;
    assign count         = count_r;

    // Read sequencer next-state: IDLE -> FETCH on an accepted request, FETCH -> RESP, RESP -> IDLE on handshake.
    always_comb begin
        state_nxt_s = state_r;
        rd_ack_s    = 1'b0;
        rd_done_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd_req && !empty) begin
                    state_nxt_s = FETCH;
                    rd_ack_s    = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                state_nxt_s = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                    rd_done_s   = 1'b1;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Read sequencer state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Write port: register the granted request one cycle after acceptance; data holds otherwise.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            load_en_r <= 1'b0;
            opa_r     <= 32'sd0;
            opb_r     <= 32'sd0;
            opc_r     <= OP_NOP;
        end else if (wr_acc_s) begin
            load_en_r <= 1'b1;
            opa_r     <= grant_s[0] ? req0_opa : req1_opa;
            opb_r     <= grant_s[0] ? req0_opb : req1_opb;
            opc_r     <= grant_s[0] ? req0_opc : req1_opc;
        end else begin
            load_en_r <= 1'b0;
            opa_r     <= opa_r;
            opb_r     <= opb_r;
            opc_r     <= opc_r;
        end
    end

    // Write pointer advances once the register has taken the write.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wptr_r <= pointer2_t'(0);
        end else if (load_en_r) begin
            wptr_r <= ptr_next(wptr_r);
        end else begin
            wptr_r <= wptr_r;
        end
    end

    // Read pointer advances when the consumer takes the response.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rptr_r <= pointer2_t'(0);
        end else if (rd_done_s) begin
            rptr_r <= ptr_next(rptr_r);
        end else begin
            rptr_r <= rptr_r;
        end
    end

    // Occupancy counts at acceptance so the full check never lets a 33rd write slip in.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({wr_acc_s, rd_done_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Response capture at the end of FETCH; valid tracks entry into RESP.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_word_r  <= instruction_t'(0);
            rsp_err_r   <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            if (state_r == FETCH) begin
                rsp_word_r <= instruction_word;
                rsp_err_r  <= ~valid;
            end else begin
                rsp_word_r <= rsp_word_r;
                rsp_err_r  <= rsp_err_r;
            end
            rsp_valid_r <= (state_nxt_s == RESP);
        end
    end

endmodule

// File: tb/tb_instr_reg_ctrl.sv
// Scoreboard bench for instr_reg_ctrl: a queue-level reference model predicts
// handshakes per cycle; expected writes and responses are checked by a monitor.
module tb_instr_reg_ctrl;
    import instr_reg_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic req0_valid, req0_ready, req1_valid, req1_ready;
    operand2_t req0_opa, req0_opb, req1_opa, req1_opb;
    opcode_t req0_opc, req1_opc;
    logic load_en;
    operand2_t operand_a, operand_b;
    opcode_t opcode;
    pointer2_t write_pointer, read_pointer;
    instruction_t instruction_word;
    logic valid;
    logic rd_req, rd_ack, rsp_valid, rsp_err, rsp_ready;
    instruction_t rsp_word;
    logic [CNT_W-1:0] count;
    logic full, empty;

    instr_reg_ctrl dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opa(req0_opa), .req0_opb(req0_opb), .req0_opc(req0_opc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opa(req1_opa), .req1_opb(req1_opb), .req1_opc(req1_opc),
        .load_en(load_en), .operand_a(operand_a), .operand_b(operand_b), .opcode(opcode),
        .write_pointer(write_pointer), .read_pointer(read_pointer),
        .instruction_word(instruction_word), .valid(valid),
        .rd_req(rd_req), .rd_ack(rd_ack),
        .rsp_valid(rsp_valid), .rsp_word(rsp_word), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural 32-entry register; an entry whose opa low nibble is F is stored as invalid.
    instruction_t mem [32];
    logic         vbit [32];
    initial for (int i = 0; i < 32; i++) begin mem[i] = '0; vbit[i] = 1'b0; end
    always @(posedge clk) begin
        if (load_en === 1'b1) begin
            mem[write_pointer]  <= {opcode, operand_a, operand_b};
            vbit[write_pointer] <= !(operand_a[3:0] == 4'hF);
        end
    end
    assign instruction_word = mem[read_pointer];
    assign valid            = vbit[read_pointer];

    typedef struct { operand2_t a; operand2_t b; opcode_t c; pointer2_t p; int due; } wexp_t;
    wexp_t        wq[$];
    instruction_t content[$];
    instruction_t rq[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: occupancy, last winner, read phase (0 idle,1 fetching,2 responding)
    int m_count = 0;
    bit m_last  = 1'b1;
    int m_ph    = 0;
    int m_rptr  = 0;
    int m_widx  = 0;
    bit m_known = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input bit v0, input bit v1, input bit rr, input bit rsr, input bit rst,
                         input operand2_t a0, input operand2_t b0, input opcode_t c0);
        int g;
        bit e_r0, e_r1, e_ack, acc, cmpl;
        instruction_t w;
        @(negedge clk);
        reset_n    = ~rst;
        req0_valid = v0; req0_opa = a0; req0_opb = b0; req0_opc = c0;
        req1_valid = v1; req1_opa = operand2_t'($urandom); req1_opb = operand2_t'($urandom);
        req1_opc   = opcode_t'(4'($urandom_range(7, 0)));
        rd_req     = rr; rsp_ready = rsr;
        #1;
        g = -1;
        if (v0 && v1) g = m_last ? 0 : 1;
        else if (v0)  g = 0;
        else if (v1)  g = 1;
        e_r0  = !rst && (m_count < DEPTH) && (g == 0);
        e_r1  = !rst && (m_count < DEPTH) && (g == 1);
        e_ack = !rst && (m_ph == 0) && rr && (m_count > 0);
        chk("req0_ready", 128'(req0_ready), 128'(e_r0));
        chk("req1_ready", 128'(req1_ready), 128'(e_r1));
        chk("rd_ack", 128'(rd_ack), 128'(e_ack));
        if (m_known) begin
            chk("count", 128'(count), 128'(m_count));
            chk("full", 128'(full), 128'(m_count == DEPTH));
            chk("empty", 128'(empty), 128'(m_count == 0));
            chk("rsp_valid", 128'(rsp_valid), 128'(m_ph == 2));
            chk("read_pointer", 128'(read_pointer), 128'(m_rptr));
        end
        if (rst) begin
            m_count = 0; m_last = 1'b1; m_ph = 0; m_rptr = 0; m_widx = 0; m_known = 1'b1;
            content.delete(); rq.delete(); wq.delete();
        end else begin
            acc  = e_r0 || e_r1;
            cmpl = (m_ph == 2) && rsr;
            if (acc) begin
                if (g == 0) w = '{opc: c0, opa: a0, opb: b0};
                else        w = '{opc: req1_opc, opa: req1_opa, opb: req1_opb};
                wq.push_back('{a: w.opa, b: w.opb, c: w.opc, p: pointer2_t'(m_widx % DEPTH), due: cyc + 1});
                content.push_back(w);
                m_widx++;
                m_last = (g == 1);
                m_count++;
            end
            if (e_ack) begin
                rq.push_back(content.pop_front());
                m_ph = 1;
            end else if (m_ph == 1) begin
                m_ph = 2;
            end else if (cmpl) begin
                m_ph = 0;
                m_rptr = (m_rptr + 1) % DEPTH;
            end
            if (cmpl) m_count--;
        end
    endtask

    task automatic idle(input int n, input bit rsr);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, rsr, 1'b0, operand2_t'($urandom), operand2_t'($urandom), OP_NOP);
    endtask

    task automatic rnd(input bit v0, input bit v1, input bit rr, input bit rsr);
        cycle(v0, v1, rr, rsr, 1'b0, operand2_t'($urandom), operand2_t'($urandom), opcode_t'(4'($urandom_range(7, 0))));
    endtask

    task automatic do_reset(input int n);
        repeat (n) cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, operand2_t'($urandom), operand2_t'($urandom), OP_ADD);
    endtask

    task automatic post_reset_checks();
        @(posedge clk); #1;
        chk("rst_load_en", 128'(load_en), 128'(0));
        chk("rst_operand_a", 128'(operand_a), 128'(0));
        chk("rst_operand_b", 128'(operand_b), 128'(0));
        chk("rst_opcode", 128'(opcode), 128'(0));
        chk("rst_rsp_word", 128'(rsp_word), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_wptr", 128'(write_pointer), 128'(0));
        chk("rst_rptr", 128'(read_pointer), 128'(0));
    endtask

    // Monitor: pops expected writes on load_en and expected responses while rsp_valid is up.
    initial begin : monitor
        wexp_t        e;
        bit           held = 1'b0;
        instruction_t hold_w;
        forever begin
            @(negedge clk); #2;
            if (reset_n !== 1'b1) begin
                held = 1'b0;
            end else begin
                if (load_en === 1'b1) begin
                    if (wq.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL load_en_unexpected: got 1 expected 0");
                    end else begin
                        e = wq.pop_front();
                        chk("wr_latency", 128'(cyc), 128'(e.due));
                        chk("wr_opa", 128'(operand_a), 128'(e.a));
                        chk("wr_opb", 128'(operand_b), 128'(e.b));
                        chk("wr_opc", 128'(opcode), 128'(e.c));
                        chk("wr_wptr", 128'(write_pointer), 128'(e.p));
                    end
                end else begin
                    while (wq.size() > 0 && wq[0].due <= cyc) begin
                        tests++; fails++;
                        $display("FAIL load_en_missing: got 0 expected 1 (due cycle %0d)", wq[0].due);
                        void'(wq.pop_front());
                    end
                end
                if (rsp_valid === 1'b1) begin
                    if (!held) begin
                        if (rq.size() == 0) begin
                            tests++; fails++;
                            $display("FAIL rsp_unexpected: got rsp_valid 1 expected 0");
                        end else begin
                            chk("rsp_word", 128'(rsp_word), 128'(rq[0]));
                            chk("rsp_err", 128'(rsp_err), 128'(rq[0].opa[3:0] == 4'hF));
                        end
                        held   = 1'b1;
                        hold_w = rsp_word;
                    end else begin
                        chk("rsp_stable", 128'(rsp_word), 128'(hold_w));
                    end
                    if (rsp_ready === 1'b1) begin
                        if (rq.size() > 0) void'(rq.pop_front());
                        held = 1'b0;
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rd_req = 1'b0; rsp_ready = 1'b0;
        req0_opa = '0; req0_opb = '0; req0_opc = OP_NOP;
        req1_opa = '0; req1_opb = '0; req1_opc = OP_NOP;

        do_reset(2);
        post_reset_checks();

        // single write from requester 0
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'sd5, 32'sd3, OP_ADD);
        idle(2, 1'b0);
        chk("single_wptr", 128'(write_pointer), 128'(1));
        chk("single_count", 128'(count), 128'(1));

        // contention: grants alternate starting with requester 0
        do_reset(1);
        post_reset_checks();
        repeat (4) rnd(1'b1, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        chk("contention_count", 128'(count), 128'(4));

        // fill to full, hold a 33rd write, then free one slot
        do_reset(1);
        repeat (32) rnd(1'b1, 1'($urandom), 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("full_flag", 128'(full), 128'(1));
        repeat (2) rnd(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) rnd(1'b1, 1'b1, 1'b1, 1'b1);
        idle(8, 1'b1);

        // read with a held response
        do_reset(1);
        rnd(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        rnd(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5, 1'b0);
        idle(2, 1'b1);

        // read request while empty
        do_reset(1);
        repeat (3) rnd(1'b0, 1'b0, 1'b1, 1'b1);

        // randomized traffic: write-heavy then read-heavy
        repeat (1500) rnd($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, 1'($urandom), 1'($urandom));
        repeat (1500) rnd($urandom_range(3, 0) == 0, $urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0, 1'($urandom));

        // reset while a response is held
        do_reset(1);
        rnd(1'b1, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        rnd(1'b0, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        do_reset(1);
        post_reset_checks();

        idle(3, 1'b1);
        chk("wq_drained", 128'(wq.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_reg_ctrl.md
INSTR_REG_CTRL -- requirements
Module: instr_reg_ctrl

Interface
REQ-001 SHALL have `clk` as an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 SHALL have `reset_n` as an input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have `req0_valid` (input, 1), `req0_ready` (output, 1), `req0_opa`/`req0_opb` (input, operand2_t, 32-bit signed) and `req0_opc` (input, opcode_t, 4-bit): requester 0 write channel.
REQ-004 SHALL have `req1_valid`, `req1_ready`, `req1_opa`, `req1_opb` and `req1_opc`, with the same directions and widths: requester 1 write channel.
REQ-005 SHALL have `load_en` (output, 1), `operand_a`/`operand_b` (output, operand2_t), `opcode` (output, opcode_t) and `write_pointer` (output, pointer2_t, 5-bit): register write port.
REQ-006 SHALL have `read_pointer` (output, pointer2_t), plus `instruction_word` (input, instruction_t) and `valid` (input, 1) from the register.
REQ-007 SHALL have `rd_req` (input, 1) and `rd_ack` (output, 1): consumer read request and acceptance.
REQ-008 SHALL have `rsp_valid` (output, 1), `rsp_word` (output, instruction_t), `rsp_err` (output, 1) and `rsp_ready` (input, 1): consumer response channel.
REQ-009 SHALL have `count` (output, 6-bit) for occupancy 0..32, plus `full` (output, 1) and `empty` (output, 1).

Function
REQ-010 SHALL treat the 32-entry register as a circular queue: writes go to `write_pointer`, reads come from `read_pointer`, and both wrap 31 -> 0.
REQ-011 SHALL compute `full` as (count==32) and `empty` as (count==0), both combinationally from `count`.
REQ-012 SHALL drive `reqN_ready` combinationally: high only when !full and requester N holds the grant this cycle.
REQ-013 SHALL arbitrate round-robin: one requester valid -> it wins; both valid -> it grants the requester not granted last; the last-grant register updates only on an accepted write.
REQ-014 SHALL register an accepted write (valid&&ready): next cycle `load_en`=1 with the granted operands, opcode and current `write_pointer`; `write_pointer` increments in the cycle after that.
REQ-015 SHALL keep `load_en` at 0 and the data outputs stable in every cycle with no accepted write.
REQ-016 SHALL make write latency exactly 1 cycle and sustain back-to-back writes at 1 per cycle until full.
REQ-017 SHALL implement the read sequencer as a three-state FSM with states IDLE, FETCH and RESP.
REQ-018 SHALL go IDLE -> FETCH when rd_req && !empty, pulsing `rd_ack` for 1 cycle; `read_pointer` is held.
REQ-019 SHALL go FETCH -> RESP after 1 cycle, capturing `instruction_word` into `rsp_word`, and setting `rsp_err` = !valid.
REQ-020 SHALL hold `rsp_valid`=1 with `rsp_word` stable while in RESP; on `rsp_ready` it goes to IDLE, increments `read_pointer` and decrements `count`.
REQ-021 SHALL ignore `rd_req` while empty, and also while not in IDLE.
REQ-022 SHALL update `count` as +1 per accepted write and -1 per RESP completion; a write accept and a read completion in the same cycle leave `count` unchanged.
REQ-023 SHALL base write acceptance on the current count, so a read completing in the same cycle as full does not free a slot until the next cycle.

Reset
REQ-024 SHALL, when reset_n==0 at a clk edge, set both pointers=0, count=0, FSM=IDLE and last-grant=requester 1 (so requester 0 wins the first tie).
REQ-025 SHALL, under reset, set load_en, rd_ack, rsp_valid and rsp_err to 0, and set operand_a, operand_b, opcode and rsp_word to 0.
REQ-026 SHALL hold reqN_ready low throughout reset, and SHALL drop any in-flight write or response, with no response completing.

Structure
REQ-027 SHALL use operand2_t, opcode_t, instruction_t, pointer2_t and a new ctrl_state_t enum (IDLE/FETCH/RESP), all from instr_reg_pkg.
REQ-028 SHALL place a DEPTH=32 constant in instr_reg_pkg, deriving the count width as $clog2(DEPTH)+1.
REQ-029 SHALL isolate the round-robin arbiter as sub-module rr_arb2 (req[1:0], accept, grant[1:0]), while the FSM and counters stay in instr_reg_ctrl.

Verification
REQ-030 SHALL cover a single write: req0 opa=5, opb=3, opc=ADD -> next cycle load_en=1, write_pointer=0; then count=1 and write_pointer=1.
REQ-031 SHALL cover contention: both requesters valid for 4 cycles after reset -> grants follow 0,1,0,1 and count=4.
REQ-032 SHALL cover full: 32 writes -> full=1 and both readies 0; a 33rd valid is held with no load_en, and after one read completes the write is accepted and write_pointer wraps to 0.
REQ-033 SHALL cover a read: with 1 entry, rd_req -> rd_ack the same cycle; rsp_valid is asserted 2 cycles later, held for 3 cycles with rsp_ready=0, and the word is unchanged throughout.
REQ-034 SHALL cover empty: rd_req=1 with count=0 -> no rd_ack and the FSM stays IDLE.
REQ-035 SHALL cover reset mid-operation: reset_n=0 during RESP -> next cycle rsp_valid=0, count=0 and both pointers=0.
